drain_seq: RTL

DRAIN_SEQ -- requirements
Module: drain_seq

---
 rtl/drain_pkg.sv | 32 +++
 rtl/drain_seq_if.sv | 23 ++
 rtl/drain_timer.sv | 27 ++
 rtl/drain_seq.sv | 68 ++++++
 4 files changed

// File: rtl/drain_pkg.sv
// Shared types and defaults for the drain sequencer: FSM states, output bundle
// and the default drain length / counter width.
package drain_pkg;

    localparam int DRAIN_CYCLES_DEF = 8;
    localparam int CNT_W_DEF        = 4;

    typedef enum logic [1:0] {
        WAIT_EN = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        HALT    = 2'd3
    } state_t;

    typedef struct packed {
        logic accept;
        logic run;
        logic bypass;
        logic halted;
    } outs_t;

    // bypass is always the inverse of run, so deriving both here keeps them consistent.
    function automatic outs_t state_outs(state_t s);
        outs_t o;
        o.accept = (s == RUN);
        o.run    = (s == RUN) || (s == DRAIN);
        o.bypass = !o.run;
        o.halted = (s == HALT);
        return o;
    endfunction

endpackage

// File: rtl/drain_seq_if.sv
// Control/status bundle between the startup sequencer / front-end and drain_seq.
interface drain_seq_if import drain_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) ();
    logic             en_start;
    logic             stop_req;
    logic             resume_req;
    logic             accept;
    logic             run;
    logic             bypass;
    logic             halted;
    logic [CNT_W-1:0] drain_cnt;

    modport master (
        output en_start, stop_req, resume_req,
        input  accept, run, bypass, halted, drain_cnt
    );

    modport slave (
        input  en_start, stop_req, resume_req,
        output accept, run, bypass, halted, drain_cnt
    );
endinterface

// File: rtl/drain_timer.sv
// Drain counter: synchronous load-to-zero, saturating increment, terminal count flag.
module drain_timer #(
    parameter int DRAIN_CYCLES = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DRAIN_CYCLES - 1);

    assign tc = (cnt == LAST);

    // NOTE: non-blocking assignments for every register so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/drain_seq.sv
// Pipeline drain sequencer: gates input off on stop, runs the pipeline for
// DRAIN_CYCLES more cycles, then halts until resumed or disabled.
module drain_seq import drain_pkg::*; #(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input logic        clk,
    input logic        rst,
    drain_seq_if.slave bus
);
    state_t           state;
    state_t           state_nxt;
    outs_t            outs;
    logic             load;
    logic             inc;
    logic             tc;
    logic [CNT_W-1:0] cnt;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_EN: if (bus.en_start)        state_nxt = RUN;
            RUN:     if (!bus.en_start)       state_nxt = WAIT_EN;
                     else if (bus.stop_req)   state_nxt = DRAIN;
            DRAIN:   if (!bus.en_start)       state_nxt = WAIT_EN;
                     else if (tc)             state_nxt = HALT;
            HALT:    if (!bus.en_start)       state_nxt = WAIT_EN;
                     else if (bus.resume_req) state_nxt = RUN;
            default:                          state_nxt = WAIT_EN;
        endcase
    end

    // Counter clears on drain entry, on resume, and whenever the block falls back to WAIT_EN.
    assign load = (state_nxt == WAIT_EN)
               || (state == RUN  && state_nxt == DRAIN)
               || (state == HALT && state_nxt == RUN);
    assign inc  = (state == DRAIN) && (state_nxt == DRAIN);

    drain_timer #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .inc  (inc),
        .cnt  (cnt),
        .tc   (tc)
    );

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_EN;
            outs  <= state_outs(WAIT_EN);
        end else begin
            state <= state_nxt;
            outs  <= state_outs(state_nxt);
        end
    end

    assign bus.accept    = outs.accept;
    assign bus.run       = outs.run;
    assign bus.bypass    = outs.bypass;
    assign bus.halted    = outs.halted;
    assign bus.drain_cnt = cnt;
endmodule
